sram_mem_controller: RTL

Sequences every MEM-stage data access onto an external 16-bit asynchronous SRAM, splitting each 32-bit word access into two half-word phases. While an access is in progress, the block drops ready, and the top level uses this to freeze the whole pipeline. The block sits between the MEM-stage control/address/data signals and the SRAM pins, replacing the internal data memory array.

---
 rtl/sram_mem_controller.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sram_mem_controller.sv
// ---------------------------------------------------------------------------
// sram_mem_controller
//   Maps MEM-stage 32-bit loads/stores onto an external 16-bit asynchronous
//   SRAM.  Each word access is split into a low half-word phase (even SRAM
//   address) and a high half-word phase (odd SRAM address).  Each phase lasts
//   ACCESS_CYCLES clocks.  ready drops while an access is in flight so the
//   pipeline can be frozen around it.
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   rd_en, wr_en        load / store request (both high = store)
//   address             byte address; BASE_ADDR maps to SRAM word 0
//   write_data          store data
//   read_data           registered load result
//   ready               high = MEM stage may advance
//   sram_addr           half-word address to the SRAM
//   sram_dq_out/_in     data to / from the SRAM
//   sram_dq_oe          drive enable for sram_dq_out (pad lives at top level)
//   sram_we_n/oe_n/ce_n/ub_n/lb_n  active-low SRAM controls
//
// state | meaning
// IDLE  | waiting for a request; latches word address, data and op
// LOW   | low half-word phase, even SRAM address
// HIGH  | high half-word phase, odd SRAM address
// DONE  | one-cycle completion, ready high, pipeline advances
// ---------------------------------------------------------------------------
module sram_mem_controller #(
   parameter int BASE_ADDR     = 1024,
   parameter int ACCESS_CYCLES = 3,
   parameter int SRAM_ADDR_W   = 18
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rd_en,
   input  logic                   wr_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [15:0]            sram_dq_out,
   input  logic [15:0]            sram_dq_in,
   output logic                   sram_dq_oe,
   output logic                   sram_we_n,
   output logic                   sram_oe_n,
   output logic                   sram_ce_n,
   output logic                   sram_ub_n,
   output logic                   sram_lb_n
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [SRAM_ADDR_W-2:0] word_q, word_d;
   logic [31:0]            wdata_q, wdata_d;
   logic                   op_q, op_d;     // 1 = write
   logic [31:0]            rdata_q, rdata_d;

   logic [31:0]            offset;
   logic                   unused_offset_bits;
   logic                   last_cycle;
   logic                   active;

   // Offsets beyond the SRAM simply wrap; only the word-address bits matter.
   assign offset             = address - 32'(BASE_ADDR);
   assign unused_offset_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

   assign last_cycle = (cnt_q == LAST_CNT);
   assign active     = (state_q == LOW) || (state_q == HIGH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
         wdata_q <= '0;
         op_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         op_q    <= op_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      wdata_d = wdata_q;
      op_d    = op_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (rd_en || wr_en) begin
               word_d  = offset[SRAM_ADDR_W:2];
               wdata_d = write_data;
               op_d    = wr_en;
               cnt_d   = '0;
               state_d = LOW;
            end
         end
         LOW: begin
            if (last_cycle) begin
               cnt_d   = '0;
               state_d = HIGH;
               if (!op_q) rdata_d[15:0] = sram_dq_in;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         HIGH: begin
            if (last_cycle) begin
               cnt_d   = '0;
               state_d = DONE;
               if (!op_q) rdata_d[31:16] = sram_dq_in;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ready     = ((state_q == IDLE) && !rd_en && !wr_en) || (state_q == DONE);
   assign read_data = rdata_q;

   always_comb begin
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      sram_oe_n   = 1'b1;
      sram_ce_n   = 1'b1;
      sram_ub_n   = 1'b1;
      sram_lb_n   = 1'b1;
      if (active) begin
         sram_ce_n = 1'b0;
         sram_ub_n = 1'b0;
         sram_lb_n = 1'b0;
         if (state_q == LOW) begin
            sram_addr   = {word_q, 1'b0};
            sram_dq_out = wdata_q[15:0];
         end else begin
            sram_addr   = {word_q, 1'b1};
            sram_dq_out = wdata_q[31:16];
         end
         if (op_q) begin
            sram_dq_oe = 1'b1;
            // WE rises on the last cycle of the phase so data and address
            // are still held at the rising edge.
            sram_we_n  = last_cycle;
         end else begin
            sram_oe_n = 1'b0;
         end
      end
   end

endmodule
